// File: rtl/seg7_scan_decoder_if.sv
// Bus between a multiplexed active-low seven-segment display drive and its scan decoder.
// Optional macro SEG7_SCAN_DP_EN adds the decimal point (seg_in bit7) and the dp_out readback.
interface seg7_scan_decoder_if #(
    parameter int NUM_DIGITS = 4
);
`ifdef SEG7_SCAN_DP_EN
    localparam int SEG_W = 8;
`else
    localparam int SEG_W = 7;
`endif

    logic [SEG_W-1:0]        seg_in;
    logic [NUM_DIGITS-1:0]   an_in;
    logic [4*NUM_DIGITS-1:0] digits_out;
    logic [NUM_DIGITS-1:0]   digit_blank;
    logic [NUM_DIGITS-1:0]   digit_err;
    logic                    frame_valid;
`ifdef SEG7_SCAN_DP_EN
    logic [NUM_DIGITS-1:0]   dp_out;
`endif

    // The display drive (or a bench standing in for it) owns the segment and enable lines.
    modport master (
        output seg_in,
        output an_in,
        input  digits_out,
        input  digit_blank,
        input  digit_err,
`ifdef SEG7_SCAN_DP_EN
        input  dp_out,
`endif
        input  frame_valid
    );

    modport slave (
        input  seg_in,
        input  an_in,
        output digits_out,
        output digit_blank,
        output digit_err,
`ifdef SEG7_SCAN_DP_EN
        output dp_out,
`endif
        output frame_valid
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Recovers per-digit BCD values from a multiplexed active-low seven-segment bus, with
// stability filtering, illegal-pattern flags and a frame pulse. Optional macro: SEG7_SCAN_DP_EN.
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input logic               clk,
    input logic               rst,
    seg7_scan_decoder_if.slave scan_io
);
`ifdef SEG7_SCAN_DP_EN
    localparam int SEG_W = 8;
`else
    localparam int SEG_W = 7;
`endif
    localparam int SAMPLE_W = NUM_DIGITS + SEG_W;
    localparam logic [7:0] CNT_MAX    = 8'(STABLE_CYCLES);
    localparam logic [7:0] CNT_COMMIT = 8'(STABLE_CYCLES - 1);

    typedef enum logic {
        SETTLE,
        HOLD
    } state_e;

    state_e                  state_q, state_d;
    logic [SAMPLE_W-1:0]     sample_in;
    logic [SAMPLE_W-1:0]     smp_q, smp_prev_q;
    logic [7:0]              cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]   smp_an;
    logic [SEG_W-1:0]        smp_seg;
    logic [NUM_DIGITS-1:0]   commit_sel;
    logic                    one_low;
    logic                    commit;

    logic [3:0]              dec_val;
    logic                    dec_blank;
    logic                    dec_err;

    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic [NUM_DIGITS-1:0]   err_q, err_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic                    frame_q, frame_d;
`ifdef SEG7_SCAN_DP_EN
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
`endif

    assign sample_in  = {scan_io.an_in, scan_io.seg_in};
    assign smp_an     = smp_q[SAMPLE_W-1:SEG_W];
    assign smp_seg    = smp_q[SEG_W-1:0];
    assign commit_sel = ~smp_an;
    assign one_low    = $onehot(commit_sel);

    // The counter restarts when the incoming pattern differs from the registered one, so a
    // pattern first registered at edge E reaches the commit count just before edge E+STABLE_CYCLES.
    always_comb begin
        cnt_d = cnt_q;
        if (sample_in != smp_q) begin
            cnt_d = 8'd0;
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            SETTLE: begin
                if ((cnt_q == CNT_COMMIT) && (smp_q == smp_prev_q) && one_low) begin
                    commit  = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (smp_q != smp_prev_q) begin
                    state_d = SETTLE;
                end
            end
            default: state_d = SETTLE;
        endcase
    end

    always_comb begin
        dec_val   = 4'hE;
        dec_blank = 1'b0;
        dec_err   = 1'b0;
        case (smp_seg[6:0])
            7'b1000000: dec_val = 4'd0;
            7'b1111001: dec_val = 4'd1;
            7'b0100100: dec_val = 4'd2;
            7'b0110000: dec_val = 4'd3;
            7'b0011001: dec_val = 4'd4;
            7'b0010010: dec_val = 4'd5;
            7'b0000010: dec_val = 4'd6;
            7'b1111000: dec_val = 4'd7;
            7'b0000000: dec_val = 4'd8;
            7'b0010000: dec_val = 4'd9;
            7'b1111111: begin
                dec_val   = 4'hF;
                dec_blank = 1'b1;
            end
            default: begin
                dec_val = 4'hE;
                dec_err = 1'b1;
            end
        endcase
    end

    // A commit only touches the selected digit; completing the seen mask fires the frame pulse.
    always_comb begin
        digits_d = digits_q;
        blank_d  = blank_q;
        err_d    = err_q;
        seen_d   = seen_q;
        frame_d  = 1'b0;
`ifdef SEG7_SCAN_DP_EN
        dp_d     = dp_q;
`endif
        if (commit) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (commit_sel[i]) begin
                    digits_d[4*i +: 4] = dec_val;
                    blank_d[i]         = dec_blank;
                    err_d[i]           = dec_err;
`ifdef SEG7_SCAN_DP_EN
                    dp_d[i]            = ~smp_seg[7];
`endif
                end
            end
            seen_d = seen_q | commit_sel;
            if (&seen_d) begin
                frame_d = 1'b1;
                seen_d  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SETTLE;
            smp_q      <= '1;
            smp_prev_q <= '1;
            cnt_q      <= 8'd0;
            digits_q   <= '1;
            blank_q    <= '1;
            err_q      <= '0;
            seen_q     <= '0;
            frame_q    <= 1'b0;
`ifdef SEG7_SCAN_DP_EN
            dp_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            smp_q      <= sample_in;
            smp_prev_q <= smp_q;
            cnt_q      <= cnt_d;
            digits_q   <= digits_d;
            blank_q    <= blank_d;
            err_q      <= err_d;
            seen_q     <= seen_d;
            frame_q    <= frame_d;
`ifdef SEG7_SCAN_DP_EN
            dp_q       <= dp_d;
`endif
        end
    end

    assign scan_io.digits_out  = digits_q;
    assign scan_io.digit_blank = blank_q;
    assign scan_io.digit_err   = err_q;
    assign scan_io.frame_valid = frame_q;
`ifdef SEG7_SCAN_DP_EN
    assign scan_io.dp_out      = dp_q;
`endif
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: latency, glitch rejection, decode flags,
// frame pulse and reset behaviour with hand-computed expectations.
module tb_seg7_scan_decoder;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_BAD   = 7'b0101010;

    logic clk;
    logic rst;
    int   assertCount = 0;
    int   failCount   = 0;
    int   framePulses = 0;
    int   pulseBase;

    seg7_scan_decoder_if #(.NUM_DIGITS(4)) bus ();

    seg7_scan_decoder #(
        .NUM_DIGITS(4),
        .STABLE_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .scan_io(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.frame_valid) framePulses++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] an, input logic [6:0] seg);
        bus.an_in       = an;
        bus.seg_in[6:0] = seg;
`ifdef SEG7_SCAN_DP_EN
        bus.seg_in[7]   = 1'b1;
`endif
    endtask

    task automatic holdCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic applyReset();
        applyStimulus(4'b1111, SEG_BLANK);
        rst = 1'b1;
        holdCycles(2);
        rst = 1'b0;
    endtask

    // Drive one digit for the full ten-cycle slot; the commit is visible after the ninth edge.
    task automatic scanDigit(input logic [3:0] an, input logic [6:0] seg);
        applyStimulus(an, seg);
        holdCycles(10);
    endtask

    initial begin
        rst = 1'b0;
        applyStimulus(4'b1111, SEG_BLANK);
        @(negedge clk);
        applyReset();

        checkOutput("reset_digits", 32'(bus.digits_out), 32'h0000FFFF);
        checkOutput("reset_blank", 32'(bus.digit_blank), 32'hF);
        checkOutput("reset_err", 32'(bus.digit_err), 32'h0);
        checkOutput("reset_frame", 32'(bus.frame_valid), 32'h0);

        // Single digit, exact latency: nothing before edge E+8, value after it.
        pulseBase = framePulses;
        applyStimulus(4'b1110, SEG_3);
        holdCycles(8);
        checkOutput("lat_not_early", 32'(bus.digits_out), 32'h0000FFFF);
        holdCycles(1);
        checkOutput("lat_digit0_val", 32'(bus.digits_out), 32'h0000FFF3);
        checkOutput("lat_digit0_blank", 32'(bus.digit_blank), 32'hE);
        checkOutput("lat_digit0_err", 32'(bus.digit_err), 32'h0);
        holdCycles(50);
        checkOutput("hold_digits", 32'(bus.digits_out), 32'h0000FFF3);
        checkOutput("hold_no_frame", 32'(framePulses - pulseBase), 32'd0);

        // Full scan 2,0,1,9: exactly one frame pulse, on the digit-3 commit only.
        pulseBase = framePulses;
        scanDigit(4'b1110, SEG_2);
        scanDigit(4'b1101, SEG_0);
        scanDigit(4'b1011, SEG_1);
        applyStimulus(4'b0111, SEG_9);
        holdCycles(9);
        checkOutput("scan_frame_pulse", 32'(bus.frame_valid), 32'h1);
        checkOutput("scan_digits", 32'(bus.digits_out), 32'h00009102);
        checkOutput("scan_blank", 32'(bus.digit_blank), 32'h0);
        holdCycles(1);
        checkOutput("scan_frame_one_cycle", 32'(bus.frame_valid), 32'h0);
        checkOutput("scan_pulse_count", 32'(framePulses - pulseBase), 32'd1);

        // Glitch of seven samples never commits; all-high or multi-low enables never commit.
        applyReset();
        pulseBase = framePulses;
        applyStimulus(4'b1101, SEG_2);
        holdCycles(7);
        applyStimulus(4'b1111, SEG_2);
        holdCycles(20);
        checkOutput("glitch_digit1", 32'(bus.digits_out[7:4]), 32'hF);
        applyStimulus(4'b1100, SEG_0);
        holdCycles(20);
        checkOutput("multi_low_digits", 32'(bus.digits_out), 32'h0000FFFF);
        checkOutput("multi_low_blank", 32'(bus.digit_blank), 32'hF);
        checkOutput("no_commit_frames", 32'(framePulses - pulseBase), 32'd0);

        // Illegal pattern flags err, then the blank pattern clears it and sets blank.
        applyStimulus(4'b1011, SEG_BAD);
        holdCycles(10);
        checkOutput("illegal_val", 32'(bus.digits_out[11:8]), 32'hE);
        checkOutput("illegal_err", 32'(bus.digit_err), 32'h4);
        checkOutput("illegal_blank", 32'(bus.digit_blank), 32'hB);
        applyStimulus(4'b1011, SEG_BLANK);
        holdCycles(10);
        checkOutput("blank_val", 32'(bus.digits_out[11:8]), 32'hF);
        checkOutput("blank_err", 32'(bus.digit_err), 32'h0);
        checkOutput("blank_blank", 32'(bus.digit_blank), 32'hF);

        // Reset discards a partial frame: digit 3 alone must not complete it afterwards.
        applyReset();
        scanDigit(4'b1110, SEG_1);
        scanDigit(4'b1101, SEG_2);
        scanDigit(4'b1011, SEG_3);
        checkOutput("partial_digits", 32'(bus.digits_out), 32'h0000F321);
        applyReset();
        checkOutput("rst_mid_digits", 32'(bus.digits_out), 32'h0000FFFF);
        checkOutput("rst_mid_blank", 32'(bus.digit_blank), 32'hF);
        checkOutput("rst_mid_err", 32'(bus.digit_err), 32'h0);
        pulseBase = framePulses;
        scanDigit(4'b0111, SEG_9);
        checkOutput("rst_digit3_no_frame", 32'(framePulses - pulseBase), 32'd0);
        scanDigit(4'b1110, SEG_0);
        scanDigit(4'b1101, SEG_1);
        applyStimulus(4'b1011, SEG_2);
        holdCycles(9);
        checkOutput("rescan_frame_pulse", 32'(bus.frame_valid), 32'h1);
        checkOutput("rescan_digits", 32'(bus.digits_out), 32'h00009210);
        holdCycles(1);
        checkOutput("rescan_pulse_count", 32'(framePulses - pulseBase), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
